// File: rtl/ball_motion_ctrl.sv
// Serve/play/point sequencer for the ball's horizontal motion. It latches pixel
// coincidences during a frame and commits direction, speed and score decisions at frame end.
module ball_motion_ctrl #(
  parameter int p_SPEED_INIT    = 1,
  parameter int p_SPEED_MAX     = 4,
  parameter int p_HITS_PER_STEP = 4,
  parameter int p_SERVE_FRAMES  = 60
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_BallVideo,
  input  logic       i_LPaddleVideo,
  input  logic       i_RPaddleVideo,
  input  logic       i_LEdge,
  input  logic       i_REdge,
  input  logic       i_Start,
  output logic       o_HDir,
  output logic [2:0] o_Speed,
  output logic       o_Serve,
  output logic       o_ScoreL,
  output logic       o_ScoreR,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    POINT = 2'd3
  } state_t;

  localparam int FC_W = (p_SERVE_FRAMES  > 1) ? $clog2(p_SERVE_FRAMES)  : 1;
  localparam int HC_W = (p_HITS_PER_STEP > 1) ? $clog2(p_HITS_PER_STEP) : 1;

  localparam logic [FC_W-1:0] FC_LAST    = FC_W'(p_SERVE_FRAMES - 1);
  localparam logic [HC_W-1:0] HC_LAST    = HC_W'(p_HITS_PER_STEP - 1);
  localparam logic [2:0]      SPEED_INIT = 3'(p_SPEED_INIT);
  localparam logic [2:0]      SPEED_MAX  = 3'(p_SPEED_MAX);

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= SPEED_MAX) ? SPEED_MAX : v + 3'd1;
  endfunction

  state_t          state, state_nxt;
  logic            hdir, hdir_nxt;
  logic [2:0]      speed, speed_nxt;
  logic [HC_W-1:0] hit_cnt, hit_cnt_nxt;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
  logic            hit_l, hit_r, miss_l, miss_r;
  logic            hit_l_nxt, hit_r_nxt, miss_l_nxt, miss_r_nxt;
  logic            score_l, score_r, score_l_nxt, score_r_nxt;

  logic fe, in_play;
  logic hit_l_now, hit_r_now, miss_l_now, miss_r_now;

  assign fe      = i_HReset & i_VReset;
  assign in_play = (state == PLAY);

  // The frame-end pixel itself still counts toward this frame's decision.
  assign hit_l_now  = hit_l  | (i_BallVideo & i_LPaddleVideo);
  assign hit_r_now  = hit_r  | (i_BallVideo & i_RPaddleVideo);
  assign miss_l_now = miss_l | (i_BallVideo & i_LEdge);
  assign miss_r_now = miss_r | (i_BallVideo & i_REdge);

  always_comb begin
    state_nxt     = state;
    hdir_nxt      = hdir;
    speed_nxt     = speed;
    hit_cnt_nxt   = hit_cnt;
    frame_cnt_nxt = frame_cnt;
    score_l_nxt   = 1'b0;
    score_r_nxt   = 1'b0;
    hit_l_nxt     = 1'b0;
    hit_r_nxt     = 1'b0;
    miss_l_nxt    = 1'b0;
    miss_r_nxt    = 1'b0;

    if (in_play && !fe) begin
      hit_l_nxt  = hit_l_now;
      hit_r_nxt  = hit_r_now;
      miss_l_nxt = miss_l_now;
      miss_r_nxt = miss_r_now;
    end

    case (state)
      IDLE: begin
        if (fe && i_Start) begin
          state_nxt     = SERVE;
          frame_cnt_nxt = '0;
        end
      end
      SERVE: begin
        if (fe) begin
          if (frame_cnt == FC_LAST) begin
            state_nxt     = PLAY;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + FC_W'(1);
          end
        end
      end
      PLAY: begin
        // Only contacts on the side the ball is heading toward matter.
        if (fe) begin
          if ((hit_l_now && !hdir) || (hit_r_now && hdir)) begin
            hdir_nxt = ~hdir;
            if (hit_cnt == HC_LAST) begin
              hit_cnt_nxt = '0;
              speed_nxt   = sat_inc(speed);
            end else begin
              hit_cnt_nxt = hit_cnt + HC_W'(1);
            end
          end else if (miss_l_now && !hdir) begin
            score_r_nxt = 1'b1;
            state_nxt   = POINT;
            speed_nxt   = SPEED_INIT;
            hit_cnt_nxt = '0;
            hdir_nxt    = 1'b0;
          end else if (miss_r_now && hdir) begin
            score_l_nxt = 1'b1;
            state_nxt   = POINT;
            speed_nxt   = SPEED_INIT;
            hit_cnt_nxt = '0;
            hdir_nxt    = 1'b1;
          end
        end
      end
      POINT: begin
        if (fe) begin
          state_nxt     = SERVE;
          frame_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= IDLE;
      hdir      <= 1'b1;
      speed     <= SPEED_INIT;
      hit_cnt   <= '0;
      frame_cnt <= '0;
      hit_l     <= 1'b0;
      hit_r     <= 1'b0;
      miss_l    <= 1'b0;
      miss_r    <= 1'b0;
      score_l   <= 1'b0;
      score_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hdir      <= hdir_nxt;
      speed     <= speed_nxt;
      hit_cnt   <= hit_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      hit_l     <= hit_l_nxt;
      hit_r     <= hit_r_nxt;
      miss_l    <= miss_l_nxt;
      miss_r    <= miss_r_nxt;
      score_l   <= score_l_nxt;
      score_r   <= score_r_nxt;
    end
  end

  assign o_State  = state;
  assign o_HDir   = hdir;
  assign o_Speed  = in_play ? speed : 3'd0;
  assign o_Serve  = ~in_play;
  assign o_ScoreL = score_l;
  assign o_ScoreR = score_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed rally/serve/point scenarios followed by random
// pixel traffic, all checked cycle by cycle against a frame-level behavioural model.
module tb_ball_motion_ctrl;

  localparam int SPEED_INIT = 1;
  localparam int SPEED_MAX  = 4;
  localparam int HITS       = 4;
  localparam int SERVE_FR   = 60;
  localparam int H = 8;
  localparam int V = 4;
  localparam int FRAME = H * V;

  localparam logic [4:0] EV_NONE = 5'b00000;  // {ball, lpad, rpad, ledge, redge}
  localparam logic [4:0] EV_LP   = 5'b11000;
  localparam logic [4:0] EV_RP   = 5'b10100;
  localparam logic [4:0] EV_LE   = 5'b10010;
  localparam logic [4:0] EV_LPLE = 5'b11010;

  logic clk = 1'b0;
  logic rst, hres, vres, ball, lp, rp, le, re, st;
  logic       o_HDir, o_Serve, o_ScoreL, o_ScoreR;
  logic [2:0] o_Speed;
  logic [1:0] o_State;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state: whole-rally quantities rather than register images.
  int m_state, m_bounces, m_frames;
  bit m_dir, m_sl, m_sr;
  bit seen_hl, seen_hr, seen_ml, seen_mr;

  always #5 clk = ~clk;

  ball_motion_ctrl #(
    .p_SPEED_INIT(SPEED_INIT), .p_SPEED_MAX(SPEED_MAX),
    .p_HITS_PER_STEP(HITS), .p_SERVE_FRAMES(SERVE_FR)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_HReset(hres), .i_VReset(vres),
    .i_BallVideo(ball), .i_LPaddleVideo(lp), .i_RPaddleVideo(rp),
    .i_LEdge(le), .i_REdge(re), .i_Start(st),
    .o_HDir(o_HDir), .o_Speed(o_Speed), .o_Serve(o_Serve),
    .o_ScoreL(o_ScoreL), .o_ScoreR(o_ScoreR), .o_State(o_State)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_speed();
    int s;
    s = SPEED_INIT + m_bounces / HITS;
    if (s > SPEED_MAX) s = SPEED_MAX;
    return (m_state == 2) ? s : 0;
  endfunction

  task automatic model_update();
    bit fe, hl, hr, ml, mr;
    fe = hres && vres;
    if (rst) begin
      m_state = 0; m_dir = 1; m_bounces = 0; m_frames = 0;
      m_sl = 0; m_sr = 0;
      seen_hl = 0; seen_hr = 0; seen_ml = 0; seen_mr = 0;
      return;
    end
    hl = seen_hl || (ball && lp);
    hr = seen_hr || (ball && rp);
    ml = seen_ml || (ball && le);
    mr = seen_mr || (ball && re);
    m_sl = 0; m_sr = 0;
    if (m_state == 2 && !fe) begin
      seen_hl = hl; seen_hr = hr; seen_ml = ml; seen_mr = mr;
    end else begin
      seen_hl = 0; seen_hr = 0; seen_ml = 0; seen_mr = 0;
    end
    if (fe) begin
      case (m_state)
        0: if (st) begin m_state = 1; m_frames = 0; end
        1: begin
          m_frames++;
          if (m_frames == SERVE_FR) m_state = 2;
        end
        2: begin
          if (hl && !m_dir) begin m_dir = 1; m_bounces++; end
          else if (hr && m_dir) begin m_dir = 0; m_bounces++; end
          else if (ml && !m_dir) begin m_sr = 1; m_state = 3; m_bounces = 0; m_dir = 0; end
          else if (mr && m_dir) begin m_sl = 1; m_state = 3; m_bounces = 0; m_dir = 1; end
        end
        default: begin m_state = 1; m_frames = 0; end
      endcase
    end
  endtask

  task automatic step();
    logic [31:0] exp;
    @(posedge clk);
    model_update();
    @(negedge clk);
    exp = 32'((m_state << 7) | (int'(m_dir) << 6) | (model_speed() << 3) |
              ((m_state == 2 ? 0 : 1) << 2) | (int'(m_sl) << 1) | int'(m_sr));
    check("cycle_outputs",
          32'({o_State, o_HDir, o_Speed, o_Serve, o_ScoreL, o_ScoreR}), exp);
  endtask

  task automatic set_pos(input int c);
    hres = ((c % H) == H - 1);
    vres = ((c / H) == V - 1);
  endtask

  task automatic run_part(input logic [4:0] ev, input int pos, input int len,
                          input logic start, input int c0, input int c1, input int rst_at);
    for (int c = c0; c <= c1; c++) begin
      set_pos(c);
      {ball, lp, rp, le, re} = (c >= pos && c < pos + len) ? ev : EV_NONE;
      st  = start;
      rst = (c == rst_at);
      step();
    end
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [4:0] ev, input int pos, input int len, input logic start);
    run_part(ev, pos, len, start, 0, FRAME - 1, -1);
  endtask

  task automatic bounce_frames(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_dir) run_frame(EV_RP, 12, 2, 1'b0);
      else       run_frame(EV_LP, 12, 2, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; st = 1'b0;
    {ball, lp, rp, le, re} = EV_NONE;
    set_pos(0);
    step(); step();
    check("reset_state", 32'(o_State), 32'd0);
    check("reset_serve", 32'(o_Serve), 32'd1);
    check("reset_hdir",  32'(o_HDir),  32'd1);
    check("reset_speed", 32'(o_Speed), 32'd0);
    rst = 1'b0;

    run_frame(EV_NONE, 0, 0, 1'b0);
    check("idle_no_start", 32'(o_State), 32'd0);
    run_frame(EV_NONE, 0, 0, 1'b1);
    check("start_to_serve", 32'(o_State), 32'd1);
    for (int f = 0; f < SERVE_FR - 1; f++) run_frame(EV_NONE, 0, 0, 1'b0);
    check("serve_held_59", 32'(o_State), 32'd1);
    check("serve_speed0",  32'(o_Speed), 32'd0);
    run_frame(EV_NONE, 0, 0, 1'b0);
    check("play_state", 32'(o_State), 32'd2);
    check("play_serve", 32'(o_Serve), 32'd0);
    check("play_speed", 32'(o_Speed), 32'd1);
    check("play_hdir",  32'(o_HDir),  32'd1);

    run_frame(EV_RP, 10, 3, 1'b0);
    check("rhit_dir", 32'(o_HDir), 32'd0);
    run_frame(EV_RP, 10, 3, 1'b0);
    check("rhit_repeat_ignored", 32'(o_HDir), 32'd0);
    run_frame(EV_LP, 4, 1, 1'b0);
    run_frame(EV_RP, 20, 2, 1'b0);
    run_frame(EV_LP, FRAME - 1, 1, 1'b0);  // contact on the frame-end pixel
    check("speed_after_4", 32'(o_Speed), 32'd2);
    check("hdir_after_4",  32'(o_HDir),  32'd1);
    bounce_frames(12);
    check("speed_sat_16", 32'(o_Speed), 32'd4);
    bounce_frames(4);
    check("speed_sat_20", 32'(o_Speed), 32'd4);

    run_frame(EV_RP, 8, 2, 1'b0);
    run_frame(EV_LPLE, 9, 2, 1'b0);
    check("hit_beats_miss_dir",   32'(o_HDir),   32'd1);
    check("hit_beats_miss_score", 32'(o_ScoreR), 32'd0);
    check("hit_beats_miss_state", 32'(o_State),  32'd2);

    run_frame(EV_RP, 8, 2, 1'b0);
    run_frame(EV_LE, 15, 2, 1'b0);
    check("miss_scoreR", 32'(o_ScoreR), 32'd1);
    check("miss_scoreL", 32'(o_ScoreL), 32'd0);
    check("miss_state",  32'(o_State),  32'd3);
    check("miss_speed",  32'(o_Speed),  32'd0);
    check("miss_hdir",   32'(o_HDir),   32'd0);
    run_frame(EV_NONE, 0, 0, 1'b0);
    check("point_to_serve", 32'(o_State), 32'd1);
    for (int f = 0; f < SERVE_FR; f++) run_frame(EV_NONE, 0, 0, 1'b0);
    check("reserve_state", 32'(o_State), 32'd2);
    check("reserve_speed", 32'(o_Speed), 32'd1);
    check("reserve_hdir",  32'(o_HDir),  32'd0);

    run_part(EV_LE, 5, 3, 1'b0, 0, 12, 12);
    check("midreset_state", 32'(o_State), 32'd0);
    check("midreset_speed", 32'(o_Speed), 32'd0);
    check("midreset_serve", 32'(o_Serve), 32'd1);
    check("midreset_hdir",  32'(o_HDir),  32'd1);
    run_part(EV_NONE, 0, 0, 1'b0, 13, FRAME - 1, -1);
    check("midreset_no_score", 32'({o_ScoreL, o_ScoreR}), 32'd0);

    for (int f = 0; f < 400; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        set_pos(c);
        ball = ($urandom_range(3) == 0);
        lp   = ($urandom_range(5) == 0);
        rp   = ($urandom_range(5) == 0);
        le   = ($urandom_range(5) == 0);
        re   = ($urandom_range(5) == 0);
        st   = ($urandom_range(1) == 0);
        rst  = ($urandom_range(3999) == 0);
        step();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Frame-rate controller that sequences the ball's horizontal motion datapath.
- Drives its direction (o_HDir) and per-frame step count (o_Speed).
- Detects paddle bounces and missed balls from pixel-coincidence of video signals; runs a serve/play/point state machine; emits score strobes to the scoreboard.
- Sits between the VGA timing generator, the paddle/ball video generators and the ball position counters.

Parameters:
- p_SPEED_INIT, 1: speed loaded at reset and after every point (pixels per frame).
- p_SPEED_MAX, 4: saturation limit for speed; must be ≤ 7.
- p_HITS_PER_STEP, 4: paddle bounces per speed increment; ≥ 1.
- p_SERVE_FRAMES, 60: frames the ball is held in serve before play; ≥ 1.

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  synchronous, active-high reset
- i_HReset  in  1  last pixel of a line
- i_VReset  in  1  last line of a frame; frame end (FE) = i_HReset && i_VReset
- i_BallVideo  in  1  ball pixel visible (horizontal AND vertical component)
- i_LPaddleVideo  in  1  left paddle pixel visible
- i_RPaddleVideo  in  1  right paddle pixel visible
- i_LEdge  in  1  first visible column
- i_REdge  in  1  last visible column
- i_Start  in  1  serve button, level, pre-debounced
- o_HDir  out  1  1 = ball moves right, 0 = left
- o_Speed  out  3  steps per frame fed to the horizontal datapath; 0 = ball frozen
- o_Serve  out  1  high while the ball is held centred/hidden
- o_ScoreL  out  1  one-cycle pulse: left player scored
- o_ScoreR  out  1  one-cycle pulse: right player scored
- o_State  out  2  current state, for debug

Behaviour:
- All state changes on posedge i_Clk. i_Reset dominates every other input, including mid-frame.
- Reset values:
  - state IDLE
  - o_HDir 1, o_Speed 0, o_Serve 1, o_ScoreL/R 0
  - internal speed reg = p_SPEED_INIT, hit counter 0, all flags 0, frame counter 0.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3.
- o_Speed = internal speed reg in PLAY, else 0.
- o_Serve = 1 in every state except PLAY.
- o_HDir and o_Speed change only on the FE edge, so both are stable for the whole following frame, including its VBlank.
- Sticky flags, set only in PLAY, any cycle of the frame:
  - hitL = Ball & LPaddle
  - hitR = Ball & RPaddle
  - missL = Ball & LEdge
  - missR = Ball & REdge
  - All flags are cleared on every FE edge and whenever state ≠ PLAY.
  - The current FE cycle's own pixel is included in the evaluation (flag OR input).
- IDLE: at FE with i_Start=1 → SERVE, frame counter cleared. i_Start outside FE is ignored.
- SERVE: frame counter increments at each FE. At the FE where counter = p_SERVE_FRAMES−1 → PLAY.
- PLAY, evaluated at FE in priority order:
  1. hitL && o_HDir=0 → o_HDir←1, bounce.
  2. hitR && o_HDir=1 → o_HDir←0, bounce.
  3. missL && o_HDir=0 → o_ScoreR pulse, POINT.
  4. missR && o_HDir=1 → o_ScoreL pulse, POINT.
  5. Otherwise no change.
  - A paddle hit beats an edge miss in the same frame.
  - A hit or miss on the side the ball is moving away from is ignored, which prevents double bounces.
- Bounce accounting:
  - If hit counter = p_HITS_PER_STEP−1: counter←0 and speed←min(speed+1, p_SPEED_MAX).
  - Else counter+1.
  - Speed never wraps.
- POINT:
  - On entry: speed←p_SPEED_INIT, hit counter←0.
  - o_HDir←direction toward the conceding player (0 if left missed, 1 if right missed).
  - At the next FE → SERVE with frame counter cleared. No i_Start is needed after the first serve.
- Score pulses are registered: high exactly the one cycle after the FE edge that made the decision, never both at once.
- Latency: input pixel to flag is 1 cycle. FE to outputs is 1 edge.

Test Plan:
- Reset then i_Start=1 at FE → o_State 0→1; o_Speed=0 and o_Serve=1 for 60 FEs; on the 60th FE o_State=2, o_Serve=0, o_Speed=1, o_HDir=1.
- PLAY, o_HDir=1, Ball&RPaddle for 3 cycles mid-frame → at FE o_HDir=0, no score pulse; a repeat RPaddle hit next frame leaves o_HDir=0.
- 4 alternating bounces → o_Speed 1→2 after the 4th FE; 12 more bounces → o_Speed saturates at 4 and stays 4 after the 20th bounce.
- PLAY, o_HDir=0, Ball&LEdge with no paddle → o_ScoreR high exactly 1 cycle after FE, o_State=3, o_Speed=0, o_HDir=0; next FE o_State=1; speed 1 after serve.
- Same frame Ball&LPaddle and Ball&LEdge, o_HDir=0 → bounce (o_HDir=1), no score.
- i_Reset pulsed mid-frame in PLAY with flags set → next cycle o_State=0, o_Speed=0, o_Serve=1, o_HDir=1, and no score pulse at the following FE.
